// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank
//   Double-buffered configuration register file. Command-side writes land in
//   a shadow array. A commit strobe copies the whole shadow array into the
//   active array in one edge. The active array drives the packed cfg_data bus.
//   The block also provides per-register write protection, a global lock,
//   self-clearing pulse registers, registered read-back and a count of
//   rejected writes.
//
// Ports
//   SCK        clock; all state updates happen on the rising edge
//   RST        asynchronous, active-high reset
//   reg_addr   write address
//   reg_value  write data
//   wr_en      write request
//   commit     shadow-to-active transfer request
//   lock       level input; while high, every write is rejected
//   rd_addr    read-back address (reads the shadow array)
//   rd_data    registered shadow read-back, one cycle of latency
//   cfg_data   packed active array; register i sits at [i*DATA_W +: DATA_W]
//   pending    high when an accepted write has not been committed yet
//   wr_err     one-cycle pulse after a rejected write
//   err_cnt    saturating count of rejected writes
module cfg_reg_bank #(
  parameter int                  NUM_REGS = 36,
  parameter int                  DATA_W   = 8,
  parameter int                  ADDR_W   = 6,
  parameter int                  OUT_W    = 512,
  parameter logic [NUM_REGS-1:0] WMASK    = '1,
  parameter logic [NUM_REGS-1:0] SCMASK   = '0,
  parameter int                  ERR_W    = 8
) (
  input  logic              SCK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_value,
  input  logic              wr_en,
  input  logic              commit,
  input  logic              lock,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [OUT_W-1:0]  cfg_data,
  output logic              pending,
  output logic              wr_err,
  output logic [ERR_W-1:0]  err_cnt
);

  // Reject parameter sets that cannot be packed onto the bus or addressed.
  if (OUT_W < NUM_REGS * DATA_W) begin : g_bad_out_w
    $fatal(1, "cfg_reg_bank: OUT_W too small for NUM_REGS*DATA_W");
  end
  if (NUM_REGS > (1 << ADDR_W)) begin : g_bad_addr_w
    $fatal(1, "cfg_reg_bank: NUM_REGS exceeds 2**ADDR_W");
  end

  logic [DATA_W-1:0]   shadow [NUM_REGS];
  logic [DATA_W-1:0]   active [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic                wr_accept;
  logic                wr_reject;
  logic [DATA_W-1:0]   rd_next;

  // Address decode is done as a one-hot compare per register. Out-of-range
  // addresses therefore match nothing, and no array index can go past the end.
  // A read-only register never gets a hit. Its shadow and active entries
  // keep their reset value.
  always_comb begin
    wr_hit  = '0;
    rd_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && !lock && WMASK[i] && (reg_addr == ADDR_W'(i)))
        wr_hit[i] = 1'b1;
      if (rd_addr == ADDR_W'(i))
        rd_next = shadow[i];
    end
    wr_accept = |wr_hit;
    wr_reject = wr_en && !wr_accept;
  end

  // Shadow/active update.
  // On commit, a write accepted at the same edge is forwarded into active.
  // Self-clearing registers wipe their shadow entry on commit, so the pulse
  // cannot be committed a second time. Outside a commit, their active entry
  // drops back to zero after one cycle.
  always_ff @(posedge SCK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit)
          active[i] <= wr_hit[i] ? reg_value : shadow[i];
        else if (SCMASK[i])
          active[i] <= '0;

        if (commit && SCMASK[i])
          shadow[i] <= '0;
        else if (wr_hit[i])
          shadow[i] <= reg_value;
      end
    end
  end

  // Read-back, pending flag and error accounting.
  // rd_data deliberately samples the pre-write shadow value (no bypass).
  always_ff @(posedge SCK or posedge RST) begin
    if (RST) begin
      rd_data <= '0;
      pending <= 1'b0;
      wr_err  <= 1'b0;
      err_cnt <= '0;
    end else begin
      rd_data <= rd_next;
      wr_err  <= wr_reject;
      if (commit)
        pending <= 1'b0;
      else if (wr_accept)
        pending <= 1'b1;
      if (wr_reject && (err_cnt != {ERR_W{1'b1}}))
        err_cnt <= err_cnt + 1'b1;
    end
  end

  // Pack the active array onto the bus. Unused upper bits stay zero.
  always_comb begin
    cfg_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cfg_data[i*DATA_W +: DATA_W] = active[i];
  end

endmodule

// File: tb/tb_cfg_reg_bank.sv
// tb_cfg_reg_bank
//   Scoreboard bench for cfg_reg_bank. Each stimulus cycle updates a
//   behavioural model of the register bank and pushes the expected outputs
//   onto a queue. After the clock edge, the entry is popped and compared
//   against the DUT.
module tb_cfg_reg_bank;

  localparam int NR = 36;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int OW = 512;
  localparam int EW = 8;
  localparam logic [NR-1:0] WM = ~(NR'(1) << 9);
  localparam logic [NR-1:0] SC = NR'(1) << 3;

  logic          SCK;
  logic          RST;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_value;
  logic          wr_en;
  logic          commit;
  logic          lock;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [OW-1:0] cfg_data;
  logic          pending;
  logic          wr_err;
  logic [EW-1:0] err_cnt;

  cfg_reg_bank #(
    .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .OUT_W(OW),
    .WMASK(WM), .SCMASK(SC), .ERR_W(EW)
  ) dut (
    .SCK(SCK), .RST(RST), .reg_addr(reg_addr), .reg_value(reg_value),
    .wr_en(wr_en), .commit(commit), .lock(lock), .rd_addr(rd_addr),
    .rd_data(rd_data), .cfg_data(cfg_data), .pending(pending),
    .wr_err(wr_err), .err_cnt(err_cnt)
  );

  // 10-time-unit clock.
  initial SCK = 1'b0;
  always #5 SCK = ~SCK;

  typedef struct {
    logic [DW-1:0] rd;
    logic [OW-1:0] cfg;
    logic          pend;
    logic          werr;
    logic [EW-1:0] ecnt;
  } exp_t;

  exp_t sb[$];

  logic [DW-1:0] m_sh  [NR];
  logic [DW-1:0] m_act [NR];
  logic          m_pend;
  logic [EW-1:0] m_err;

  int total = 0;
  int bad   = 0;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [OW-1:0] obs,
                             input logic [OW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] packModel();
    logic [OW-1:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_act[i];
    return v;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < NR; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    m_pend = 1'b0;
    m_err  = '0;
  endtask

  // Drive one cycle of stimulus, push the model's expectation, then pop
  // and compare once the edge has been taken.
  task automatic applyStimulus(input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] v, input logic c,
                               input logic l, input logic [AW-1:0] r);
    exp_t          e;
    exp_t          got;
    logic          acc;
    logic [DW-1:0] nsh [NR];

    acc = 1'b0;
    if (w && !l && (int'(a) < NR))
      if (WM[a]) acc = 1'b1;

    e.rd = '0;
    if (int'(r) < NR) e.rd = m_sh[r];

    for (int i = 0; i < NR; i++) nsh[i] = m_sh[i];
    if (acc) nsh[a] = v;
    for (int i = 0; i < NR; i++) begin
      if (c) m_act[i] = nsh[i];
      else if (SC[i]) m_act[i] = '0;
      if (c && SC[i]) nsh[i] = '0;
      m_sh[i] = nsh[i];
    end
    if (c) m_pend = 1'b0;
    else if (acc) m_pend = 1'b1;
    e.werr = w && !acc;
    if (e.werr && m_err != 8'hFF) m_err = m_err + 8'd1;

    e.cfg  = packModel();
    e.pend = m_pend;
    e.ecnt = m_err;
    sb.push_back(e);

    wr_en = w; reg_addr = a; reg_value = v; commit = c; lock = l; rd_addr = r;
    @(posedge SCK);
    #1;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 1, 0);
    end else begin
      got = sb.pop_front();
      checkOutput("rd_data",  OW'(rd_data),  OW'(got.rd));
      checkOutput("cfg_data", cfg_data,      got.cfg);
      checkOutput("pending",  OW'(pending),  OW'(got.pend));
      checkOutput("wr_err",   OW'(wr_err),   OW'(got.werr));
      checkOutput("err_cnt",  OW'(err_cnt),  OW'(got.ecnt));
    end
    wr_en = 1'b0; commit = 1'b0; lock = 1'b0;
  endtask

  initial begin
    RST = 1'b1; wr_en = 0; commit = 0; lock = 0;
    reg_addr = '0; reg_value = '0; rd_addr = '0;
    clearModel();
    repeat (2) @(posedge SCK);
    #1;
    checkOutput("rst_cfg",  cfg_data, '0);
    checkOutput("rst_rd",   OW'(rd_data), '0);
    checkOutput("rst_pend", OW'(pending), '0);
    checkOutput("rst_err",  OW'(err_cnt), '0);
    RST = 1'b0;

    // Uncommitted write, then read-back of the shadow.
    applyStimulus(1, 6'h05, 8'hA5, 0, 0, 6'h05);
    applyStimulus(0, 6'h00, 8'h00, 0, 0, 6'h05);
    checkOutput("rd_a5", OW'(rd_data), OW'(8'hA5));
    checkOutput("uncommitted", OW'(cfg_data[47:40]), '0);
    // Commit.
    applyStimulus(0, 6'h00, 8'h00, 1, 0, 6'h05);
    checkOutput("commit_a5", OW'(cfg_data[47:40]), OW'(8'hA5));
    // Same-edge write and commit.
    applyStimulus(1, 6'h07, 8'h3C, 1, 0, 6'h07);
    checkOutput("fwd_3c", OW'(cfg_data[63:56]), OW'(8'h3C));
    // Rejections: out of range, locked, read-only.
    applyStimulus(1, 6'h24, 8'hFF, 0, 0, 6'h24);
    applyStimulus(0, 6'h00, 8'h00, 0, 0, 6'h00);
    applyStimulus(1, 6'h01, 8'h11, 0, 1, 6'h01);
    applyStimulus(1, 6'h09, 8'h99, 0, 0, 6'h09);
    applyStimulus(0, 6'h00, 8'h00, 0, 0, 6'h09);
    checkOutput("err3", OW'(err_cnt), OW'(8'd3));
    checkOutput("ro_rd", OW'(rd_data), '0);
    // Self-clearing register 3.
    applyStimulus(1, 6'h03, 8'h01, 0, 0, 6'h03);
    applyStimulus(0, 6'h00, 8'h00, 1, 0, 6'h03);
    checkOutput("sc_on", OW'(cfg_data[31:24]), OW'(8'h01));
    applyStimulus(0, 6'h00, 8'h00, 0, 0, 6'h03);
    checkOutput("sc_off", OW'(cfg_data[31:24]), '0);
    checkOutput("sc_rd", OW'(rd_data), '0);
    // SC write on the same edge as commit: active gets the pulse, shadow cleared.
    applyStimulus(1, 6'h03, 8'h80, 1, 0, 6'h03);
    applyStimulus(0, 6'h00, 8'h00, 0, 0, 6'h03);
    // Random mix of writes, commits, locks and reads.
    for (int k = 0; k < 60; k++)
      applyStimulus(1'($urandom_range(0, 1)), 6'($urandom_range(0, 39)),
                    8'($urandom), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 7) == 0), 6'($urandom_range(0, 39)));
    // Saturation of the error counter.
    for (int k = 0; k < 300; k++)
      applyStimulus(1, 6'h30, 8'($urandom), 0, 0, 6'h00);
    checkOutput("err_sat", OW'(err_cnt), OW'(8'd255));
    applyStimulus(0, 6'h00, 8'h00, 0, 0, 6'h00);
    // Asynchronous reset between edges discards the pending write.
    applyStimulus(1, 6'h10, 8'h55, 0, 0, 6'h10);
    #3;
    RST = 1'b1;
    #1;
    checkOutput("arst_cfg",  cfg_data, '0);
    checkOutput("arst_rd",   OW'(rd_data), '0);
    checkOutput("arst_pend", OW'(pending), '0);
    checkOutput("arst_err",  OW'(err_cnt), '0);
    clearModel();
    @(posedge SCK);
    #1;
    RST = 1'b0;
    applyStimulus(0, 6'h00, 8'h00, 1, 0, 6'h10);
    checkOutput("post_rst_cfg", cfg_data, '0);
    applyStimulus(0, 6'h00, 8'h00, 0, 0, 6'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
